// File: rtl/dpram_arbiter_if.sv
// Requester-side bus of the dual-port RAM arbiter: per-requester request and response lanes.
// Lane i of each packed vector belongs to requester i.
interface dpram_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 8
);
    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_we;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ-1:0]        rsp_valid;
    logic [NUM_REQ*DATA_W-1:0] rsp_data;

    // Client side drives requests and consumes grants/responses.
    modport master (
        output req_valid, req_we, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_data
    );

    // Arbiter side.
    modport slave (
        input  req_valid, req_we, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_data
    );
endinterface

// File: rtl/dpram_arbiter.sv
// Round-robin arbiter sharing one dual-port sync RAM among NUM_REQ requesters.
// Grants up to two non-conflicting requests per cycle (port A, then port B); reads return one cycle later.
module dpram_arbiter #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ADDR_W  = 4,
    parameter int unsigned DATA_W  = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    dpram_arbiter_if.slave    bus,
    output logic              ram_w_a,
    output logic [ADDR_W-1:0] ram_add_a,
    output logic [DATA_W-1:0] ram_din_a,
    input  logic [DATA_W-1:0] ram_dout_a,
    output logic              ram_w_b,
    output logic [ADDR_W-1:0] ram_add_b,
    output logic [DATA_W-1:0] ram_din_b,
    input  logic [DATA_W-1:0] ram_dout_b
);

    localparam int unsigned PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [PTR_W-1:0]  r_rr_ptr;
    logic              r_a_rd;
    logic              r_b_rd;
    logic [PTR_W-1:0]  r_a_own;
    logic [PTR_W-1:0]  r_b_own;

    logic              w_a_gnt;
    logic              w_b_gnt;
    logic [PTR_W-1:0]  w_a_idx;
    logic [PTR_W-1:0]  w_b_idx;
    logic [ADDR_W-1:0] w_addr  [NUM_REQ];
    logic [DATA_W-1:0] w_wdata [NUM_REQ];

    for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
        assign w_addr[g]  = bus.req_addr[g*ADDR_W +: ADDR_W];
        assign w_wdata[g] = bus.req_wdata[g*DATA_W +: DATA_W];
    end

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return PTR_W'((32'(p) + 32'd1) % NUM_REQ);
    endfunction

    // Round-robin scan from r_rr_ptr; port B takes the first later requester not conflicting with A.
    always_comb begin : arb_scan
        logic [PTR_W-1:0] v_idx;
        v_idx         = '0;
        w_a_gnt       = 1'b0;
        w_b_gnt       = 1'b0;
        w_a_idx       = '0;
        w_b_idx       = '0;
        bus.req_ready = '0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            v_idx = PTR_W'((32'(r_rr_ptr) + k) % NUM_REQ);
            if (rst_n && bus.req_valid[v_idx]) begin
                if (!w_a_gnt) begin
                    w_a_gnt              = 1'b1;
                    w_a_idx              = v_idx;
                    bus.req_ready[v_idx] = 1'b1;
                end else if (!w_b_gnt &&
                             !((w_addr[v_idx] == w_addr[w_a_idx]) &&
                               (bus.req_we[v_idx] || bus.req_we[w_a_idx]))) begin
                    w_b_gnt              = 1'b1;
                    w_b_idx              = v_idx;
                    bus.req_ready[v_idx] = 1'b1;
                end
            end
        end
    end

    // RAM port drive; idle ports and the data bus of read ports are held at zero.
    always_comb begin : ram_drive
        ram_w_a   = w_a_gnt && bus.req_we[w_a_idx];
        ram_add_a = w_a_gnt ? w_addr[w_a_idx] : '0;
        ram_din_a = ram_w_a ? w_wdata[w_a_idx] : '0;
        ram_w_b   = w_b_gnt && bus.req_we[w_b_idx];
        ram_add_b = w_b_gnt ? w_addr[w_b_idx] : '0;
        ram_din_b = ram_w_b ? w_wdata[w_b_idx] : '0;
    end

    // Pointer advance and read-owner tracking.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr <= '0;
            r_a_rd   <= 1'b0;
            r_b_rd   <= 1'b0;
            r_a_own  <= '0;
            r_b_own  <= '0;
        end else begin
            if (w_b_gnt) begin
                r_rr_ptr <= next_ptr(w_b_idx);
            end else if (w_a_gnt) begin
                r_rr_ptr <= next_ptr(w_a_idx);
            end
            r_a_rd  <= w_a_gnt && !bus.req_we[w_a_idx];
            r_b_rd  <= w_b_gnt && !bus.req_we[w_b_idx];
            r_a_own <= w_a_idx;
            r_b_own <= w_b_idx;
        end
    end

    // Route registered RAM read data back to the owning lane.
    always_comb begin : rsp_route
        bus.rsp_valid = '0;
        bus.rsp_data  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (r_a_rd && (r_a_own == PTR_W'(i))) begin
                bus.rsp_valid[i]                 = 1'b1;
                bus.rsp_data[i*DATA_W +: DATA_W] = ram_dout_a;
            end else if (r_b_rd && (r_b_own == PTR_W'(i))) begin
                bus.rsp_valid[i]                 = 1'b1;
                bus.rsp_data[i*DATA_W +: DATA_W] = ram_dout_b;
            end
        end
    end

endmodule

// File: tb/tb_dpram_arbiter.sv
// Directed bench for dpram_arbiter with a behavioural 16x8 dual-port sync RAM.
// Inputs change on negedge; outputs are sampled 1ns later.
module tb_dpram_arbiter;

    localparam int unsigned NR = 4;
    localparam int unsigned AW = 4;
    localparam int unsigned DW = 8;

    logic          clk;
    logic          rst_n;
    logic          ram_w_a, ram_w_b;
    logic [AW-1:0] ram_add_a, ram_add_b;
    logic [DW-1:0] ram_din_a, ram_din_b;
    logic [DW-1:0] ram_dout_a, ram_dout_b;
    logic [DW-1:0] mem [16];

    int vec_cnt;
    int err_cnt;

    dpram_arbiter_if #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) bus ();

    dpram_arbiter #(.NUM_REQ(NR), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .bus        (bus),
        .ram_w_a    (ram_w_a),
        .ram_add_a  (ram_add_a),
        .ram_din_a  (ram_din_a),
        .ram_dout_a (ram_dout_a),
        .ram_w_b    (ram_w_b),
        .ram_add_b  (ram_add_b),
        .ram_din_b  (ram_din_b),
        .ram_dout_b (ram_dout_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read-first synchronous dual-port RAM model.
    always_ff @(posedge clk) begin
        if (ram_w_a) mem[ram_add_a] <= ram_din_a;
        if (ram_w_b) mem[ram_add_b] <= ram_din_b;
        ram_dout_a <= mem[ram_add_a];
        ram_dout_b <= mem[ram_add_b];
    end

    task automatic set_req(input int i, input logic v, input logic we,
                           input logic [AW-1:0] a, input logic [DW-1:0] d);
        bus.req_valid[i]          = v;
        bus.req_we[i]             = we;
        bus.req_addr[i*AW +: AW]  = a;
        bus.req_wdata[i*DW +: DW] = d;
    endtask

    task automatic clear_reqs();
        bus.req_valid = '0;
        bus.req_we    = '0;
        bus.req_addr  = '0;
        bus.req_wdata = '0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        clear_reqs();
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) set_req(i, 1'b1, 1'b1, AW'(12 + i), DW'(8'h10 + i));
        #1;
        vec_cnt++; if (bus.req_ready !== 4'b0000) begin err_cnt++; $display("FAIL rst_ready got=%b exp=0000", bus.req_ready); end
        vec_cnt++; if ({ram_w_a, ram_w_b} !== 2'b00) begin err_cnt++; $display("FAIL rst_ram_w got=%b exp=00", {ram_w_a, ram_w_b}); end
        @(negedge clk); #1;
        vec_cnt++; if (bus.rsp_valid !== 4'b0000) begin err_cnt++; $display("FAIL rst_rsp_valid got=%b exp=0000", bus.rsp_valid); end
        vec_cnt++; if (ram_add_a !== 4'd0) begin err_cnt++; $display("FAIL rst_idle_addr got=%h exp=0", ram_add_a); end
        rst_n = 1'b1;
        #1;
        vec_cnt++; if (bus.req_ready !== 4'b0011) begin err_cnt++; $display("FAIL rel_ready got=%b exp=0011", bus.req_ready); end
        vec_cnt++; if ({ram_add_b, ram_add_a} !== 8'hDC) begin err_cnt++; $display("FAIL rel_ports got=%h exp=dc", {ram_add_b, ram_add_a}); end
        @(negedge clk);
        clear_reqs();
    endtask

    task automatic test_two_writes_reads();
        do_reset();
        set_req(0, 1'b1, 1'b1, 4'd3, 8'hA5);
        set_req(1, 1'b1, 1'b1, 4'd7, 8'h5A);
        #1;
        vec_cnt++; if (bus.req_ready !== 4'b0011) begin err_cnt++; $display("FAIL wr2_ready got=%b exp=0011", bus.req_ready); end
        vec_cnt++; if ({ram_w_a, ram_add_a, ram_din_a} !== 13'h1_3A5) begin err_cnt++; $display("FAIL wr2_port_a got=%h exp=13a5", {ram_w_a, ram_add_a, ram_din_a}); end
        vec_cnt++; if ({ram_w_b, ram_add_b, ram_din_b} !== 13'h1_75A) begin err_cnt++; $display("FAIL wr2_port_b got=%h exp=175a", {ram_w_b, ram_add_b, ram_din_b}); end
        @(negedge clk);
        set_req(0, 1'b1, 1'b0, 4'd3, 8'h00);
        set_req(1, 1'b1, 1'b0, 4'd7, 8'h00);
        #1;
        vec_cnt++; if ({bus.req_ready, ram_w_a, ram_w_b} !== 6'b0011_00) begin err_cnt++; $display("FAIL rd2_grant got=%b exp=001100", {bus.req_ready, ram_w_a, ram_w_b}); end
        @(negedge clk);
        clear_reqs();
        #1;
        vec_cnt++; if (bus.rsp_valid !== 4'b0011) begin err_cnt++; $display("FAIL rd2_rsp_valid got=%b exp=0011", bus.rsp_valid); end
        vec_cnt++; if (bus.rsp_data !== 32'h0000_5AA5) begin err_cnt++; $display("FAIL rd2_rsp_data got=%h exp=00005aa5", bus.rsp_data); end
        @(negedge clk); #1;
        vec_cnt++; if (bus.rsp_valid !== 4'b0000) begin err_cnt++; $display("FAIL rd2_rsp_pulse got=%b exp=0000", bus.rsp_valid); end
    endtask

    task automatic test_write_conflict();
        do_reset();
        set_req(0, 1'b1, 1'b1, 4'd5, 8'h11);
        set_req(2, 1'b1, 1'b1, 4'd5, 8'h22);
        #1;
        vec_cnt++; if ({bus.req_ready, ram_w_b} !== 5'b0001_0) begin err_cnt++; $display("FAIL wwc_c1 got=%b exp=00010", {bus.req_ready, ram_w_b}); end
        vec_cnt++; if (ram_din_a !== 8'h11) begin err_cnt++; $display("FAIL wwc_c1_din got=%h exp=11", ram_din_a); end
        @(negedge clk);
        set_req(0, 1'b0, 1'b0, 4'd0, 8'h00);
        #1;
        vec_cnt++; if (bus.req_ready !== 4'b0100) begin err_cnt++; $display("FAIL wwc_c2 got=%b exp=0100", bus.req_ready); end
        vec_cnt++; if ({ram_w_a, ram_add_a, ram_din_a} !== 13'h1_522) begin err_cnt++; $display("FAIL wwc_c2_port got=%h exp=1522", {ram_w_a, ram_add_a, ram_din_a}); end
        @(negedge clk);
        clear_reqs();
        set_req(1, 1'b1, 1'b0, 4'd5, 8'h00);
        #1;
        vec_cnt++; if (bus.req_ready !== 4'b0010) begin err_cnt++; $display("FAIL wwc_rd_grant got=%b exp=0010", bus.req_ready); end
        @(negedge clk);
        clear_reqs();
        #1;
        vec_cnt++; if ({bus.rsp_valid, bus.rsp_data} !== {4'b0010, 32'h0000_2200}) begin err_cnt++; $display("FAIL wwc_rsp got=%h exp=20000_2200", {bus.rsp_valid, bus.rsp_data}); end
    endtask

    task automatic test_read_write_conflict();
        do_reset();
        set_req(0, 1'b1, 1'b1, 4'd9, 8'h33);
        @(negedge clk);
        clear_reqs();
        set_req(1, 1'b1, 1'b0, 4'd9, 8'h00);
        set_req(2, 1'b1, 1'b1, 4'd9, 8'h44);
        #1;
        vec_cnt++; if ({bus.req_ready, ram_w_a, ram_w_b} !== 6'b0010_00) begin err_cnt++; $display("FAIL rwc_c1 got=%b exp=001000", {bus.req_ready, ram_w_a, ram_w_b}); end
        @(negedge clk);
        set_req(1, 1'b0, 1'b0, 4'd0, 8'h00);
        #1;
        vec_cnt++; if (bus.req_ready !== 4'b0100) begin err_cnt++; $display("FAIL rwc_c2 got=%b exp=0100", bus.req_ready); end
        vec_cnt++; if ({bus.rsp_valid, bus.rsp_data} !== {4'b0010, 32'h0000_3300}) begin err_cnt++; $display("FAIL rwc_old_rsp got=%h exp=20000_3300", {bus.rsp_valid, bus.rsp_data}); end
        @(negedge clk);
        clear_reqs();
        set_req(3, 1'b1, 1'b0, 4'd9, 8'h00);
        #1;
        vec_cnt++; if (bus.req_ready !== 4'b1000) begin err_cnt++; $display("FAIL rwc_c3 got=%b exp=1000", bus.req_ready); end
        @(negedge clk);
        clear_reqs();
        #1;
        vec_cnt++; if ({bus.rsp_valid, bus.rsp_data} !== {4'b1000, 32'h4400_0000}) begin err_cnt++; $display("FAIL rwc_new_rsp got=%h exp=84400_0000", {bus.rsp_valid, bus.rsp_data}); end
    endtask

    // Memory here: 3=A5, 7=5A, 5=22, 9=44.
    task automatic test_back_to_back();
        logic [3:0]  exp_rdy;
        logic [3:0]  prev_rdy;
        logic [31:0] exp_data;
        do_reset();
        set_req(0, 1'b1, 1'b0, 4'd3, 8'h00);
        set_req(1, 1'b1, 1'b0, 4'd7, 8'h00);
        set_req(2, 1'b1, 1'b0, 4'd5, 8'h00);
        set_req(3, 1'b1, 1'b0, 4'd9, 8'h00);
        prev_rdy = 4'b0000;
        for (int c = 0; c < 5; c++) begin
            #1;
            exp_rdy = (c % 2 == 0) ? 4'b0011 : 4'b1100;
            vec_cnt++; if (bus.req_ready !== exp_rdy) begin err_cnt++; $display("FAIL b2b_ready c=%0d got=%b exp=%b", c, bus.req_ready, exp_rdy); end
            if (c > 0) begin
                exp_data = (prev_rdy == 4'b0011) ? 32'h0000_5AA5 : 32'h4422_0000;
                vec_cnt++; if ({bus.rsp_valid, bus.rsp_data} !== {prev_rdy, exp_data}) begin err_cnt++; $display("FAIL b2b_rsp c=%0d got=%h exp=%h", c, {bus.rsp_valid, bus.rsp_data}, {prev_rdy, exp_data}); end
            end
            prev_rdy = exp_rdy;
            @(negedge clk);
        end
        clear_reqs();
        #1;
        vec_cnt++; if ({bus.rsp_valid, bus.rsp_data} !== {4'b0011, 32'h0000_5AA5}) begin err_cnt++; $display("FAIL b2b_last_rsp got=%h exp=30000_5aa5", {bus.rsp_valid, bus.rsp_data}); end
    endtask

    task automatic test_reset_inflight();
        do_reset();
        set_req(0, 1'b1, 1'b0, 4'd3, 8'h00);
        set_req(1, 1'b1, 1'b0, 4'd7, 8'h00);
        #1;
        vec_cnt++; if (bus.req_ready !== 4'b0011) begin err_cnt++; $display("FAIL rif_grant got=%b exp=0011", bus.req_ready); end
        #1;
        rst_n = 1'b0;
        set_req(0, 1'b1, 1'b1, 4'd3, 8'hFF);
        set_req(1, 1'b1, 1'b1, 4'd7, 8'hEE);
        #1;
        vec_cnt++; if ({bus.req_ready, ram_w_a, ram_w_b} !== 6'b0000_00) begin err_cnt++; $display("FAIL rif_in_rst got=%b exp=000000", {bus.req_ready, ram_w_a, ram_w_b}); end
        @(negedge clk); #1;
        vec_cnt++; if ({bus.rsp_valid, ram_w_a, ram_w_b} !== 6'b0000_00) begin err_cnt++; $display("FAIL rif_dropped got=%b exp=000000", {bus.rsp_valid, ram_w_a, ram_w_b}); end
        clear_reqs();
        rst_n = 1'b1;
        set_req(0, 1'b1, 1'b0, 4'd3, 8'h00);
        set_req(3, 1'b1, 1'b0, 4'd7, 8'h00);
        #1;
        vec_cnt++; if ({bus.req_ready, ram_add_a, ram_add_b} !== {4'b1001, 4'd3, 4'd7}) begin err_cnt++; $display("FAIL rif_ptr got=%h exp=937", {bus.req_ready, ram_add_a, ram_add_b}); end
        vec_cnt++; if (bus.rsp_valid !== 4'b0000) begin err_cnt++; $display("FAIL rif_no_rsp got=%b exp=0000", bus.rsp_valid); end
        @(negedge clk);
        clear_reqs();
        #1;
        vec_cnt++; if ({bus.rsp_valid, bus.rsp_data} !== {4'b1001, 32'h5A00_00A5}) begin err_cnt++; $display("FAIL rif_ram_intact got=%h exp=95a00_00a5", {bus.rsp_valid, bus.rsp_data}); end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_cnt = 0;
        err_cnt = 0;
        rst_n   = 1'b0;
        clear_reqs();
        test_reset();
        test_two_writes_reads();
        test_write_conflict();
        test_read_write_conflict();
        test_back_to_back();
        test_reset_inflight();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
